// File: rtl/dft_pkg.sv
// -----------------------------------------------------------------------------
// dft_pkg
// Shared definitions for the 4-point inverse DFT block:
//   - N            : transform length (4)
//   - state_e      : controller states IDLE / ACCUM / DONE
//   - cplx_t       : wide complex word used by the rotation helper
//   - rotate_j()   : multiply a complex value by j^m using only swaps and
//                    negations
// -----------------------------------------------------------------------------
package dft_pkg;

    localparam int N = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Rotation is done on a generously wide word so the helper does not need
    // a width parameter; callers sign-extend into it and truncate back out.
    // Negating the most negative caller value cannot overflow at this width.
    localparam int ROT_W = 64;

    typedef logic signed [ROT_W-1:0] rot_word_t;

    typedef struct packed {
        rot_word_t re;
        rot_word_t im;
    } cplx_t;

    // x * j^m:  m=0 -> ( re,  im)
    //           m=1 -> (-im,  re)
    //           m=2 -> (-re, -im)
    //           m=3 -> ( im, -re)
    function automatic cplx_t rotate_j(input logic [1:0] m, input cplx_t x);
        cplx_t r;
        unique case (m)
            2'd0: begin r.re =  x.re; r.im =  x.im; end
            2'd1: begin r.re = -x.im; r.im =  x.re; end
            2'd2: begin r.re = -x.re; r.im = -x.im; end
            default: begin r.re = x.im; r.im = -x.re; end
        endcase
        return r;
    endfunction

endpackage : dft_pkg

// File: rtl/dft_rot_n4.sv
// -----------------------------------------------------------------------------
// dft_rot_n4
// Purely combinational twiddle stage for the 4-point DFT: multiplies one
// complex sample by j^m without any multiplier.
//
// Ports
//   m       in  [1:0]  rotation exponent (j^m)
//   re, im  in  [W-1:0] signed input sample
//   rot_re  out [W-1:0] signed rotated real part
//   rot_im  out [W-1:0] signed rotated imaginary part
//
// W must leave one bit of headroom above the source sample width so that
// negating the most negative source value is representable.
// -----------------------------------------------------------------------------
module dft_rot_n4
    import dft_pkg::*;
#(
    parameter int W = 26
) (
    input  logic [1:0]          m,
    input  logic signed [W-1:0] re,
    input  logic signed [W-1:0] im,
    output logic signed [W-1:0] rot_re,
    output logic signed [W-1:0] rot_im
);

    cplx_t x_wide;
    cplx_t r_wide;

    // NOTE: every signal written in an always_comb gets a value on every path
    // (here unconditionally, elsewhere via a default first) so no latch is
    // inferred.
    always_comb begin
        // Signed-to-wider assignment sign-extends.
        x_wide.re = re;
        x_wide.im = im;
        r_wide    = rotate_j(m, x_wide);
        rot_re    = r_wide.re[W-1:0];
        rot_im    = r_wide.im[W-1:0];
    end

endmodule : dft_rot_n4

// File: rtl/inv_dft_n4.sv
// -----------------------------------------------------------------------------
// inv_dft_n4
// Sequential 4-point inverse DFT. On request it computes one time-domain
// sample
//     x[n] = 1/4 * sum_{k=0..3} X[k] * j^((k*n) mod 4)
// accumulating one spectral term per clock, then publishes the floor-divided
// result.
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   asynchronous, active-low reset
//   start     in   request one result (ignored while accumulating)
//   x_idx     in   [1:0] time index n to compute
//   src_real  in   [3:0][WIDTH-1:0] spectrum real parts, X[k] at [k]
//   src_imag  in   [3:0][WIDTH-1:0] spectrum imaginary parts, X[k] at [k]
//   ready     out  high while x_real/x_imag hold a completed result
//   x_real    out  [WIDTH-1:0] result real part
//   x_imag    out  [WIDTH-1:0] result imaginary part
//
// Timing: start sampled at edge E0 latches the inputs; edges E1..E4 add
// terms k=0..3; ready and the result appear after E4. With start held high
// a new result is produced every 5 clocks.
// -----------------------------------------------------------------------------
module inv_dft_n4
    import dft_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int FRAC  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            x_idx,
    input  logic [3:0][WIDTH-1:0] src_real,
    input  logic [3:0][WIDTH-1:0] src_imag,
    output logic                  ready,
    output logic [WIDTH-1:0]      x_real,
    output logic [WIDTH-1:0]      x_imag
);

    // Two guard bits: the sum of four rotated WIDTH-bit terms always fits.
    // FRAC only documents where the binary point sits; the arithmetic is
    // identical for any value, so it contributes nothing here.
    localparam int ACC_W = WIDTH + 2 + (FRAC * 0);

    localparam logic [1:0] K_LAST = 2'(N - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [1:0]              k_q, k_d;
    logic [1:0]              idx_q, idx_d;
    logic [3:0][WIDTH-1:0]   src_re_q, src_re_d;
    logic [3:0][WIDTH-1:0]   src_im_q, src_im_d;
    logic signed [ACC_W-1:0] acc_re_q, acc_re_d;
    logic signed [ACC_W-1:0] acc_im_q, acc_im_d;
    logic                    ready_q, ready_d;
    logic [WIDTH-1:0]        x_real_q, x_real_d;
    logic [WIDTH-1:0]        x_imag_q, x_imag_d;

    // ------------------------------------------------------------------
    // Datapath: select term k, rotate by j^(k*n mod 4), add
    // ------------------------------------------------------------------
    logic [1:0]              rot_m;
    logic signed [ACC_W-1:0] term_re;
    logic signed [ACC_W-1:0] term_im;
    logic signed [ACC_W-1:0] rot_re;
    logic signed [ACC_W-1:0] rot_im;
    logic signed [ACC_W-1:0] sum_re;
    logic signed [ACC_W-1:0] sum_im;

    // The 2-bit product wraps, which is exactly the mod-4 exponent.
    assign rot_m   = 2'(k_q * idx_q);
    assign term_re = ACC_W'($signed(src_re_q[k_q]));
    assign term_im = ACC_W'($signed(src_im_q[k_q]));

    dft_rot_n4 #(
        .W (ACC_W)
    ) u_rot (
        .m      (rot_m),
        .re     (term_re),
        .im     (term_im),
        .rot_re (rot_re),
        .rot_im (rot_im)
    );

    assign sum_re = acc_re_q + rot_re;
    assign sum_im = acc_im_q + rot_im;

    // A new computation may begin from IDLE or DONE, never mid-accumulation.
    logic launch;
    assign launch = start && (state_q != ST_ACCUM);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        idx_d    = idx_q;
        src_re_d = src_re_q;
        src_im_d = src_im_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        ready_d  = ready_q;
        x_real_d = x_real_q;
        x_imag_d = x_imag_q;

        unique case (state_q)
            ST_ACCUM: begin
                acc_re_d = sum_re;
                acc_im_d = sum_im;
                k_d      = k_q + 2'd1;
                if (k_q == K_LAST) begin
                    state_d  = ST_DONE;
                    ready_d  = 1'b1;
                    // Arithmetic shift by 2 is a floor divide by 4; the
                    // quotient always fits back into WIDTH bits.
                    x_real_d = sum_re[WIDTH+1:2];
                    x_imag_d = sum_im[WIDTH+1:2];
                end
            end
            ST_IDLE, ST_DONE: begin
                if (launch) begin
                    state_d  = ST_ACCUM;
                    idx_d    = x_idx;
                    src_re_d = src_real;
                    src_im_d = src_imag;
                    acc_re_d = '0;
                    acc_im_d = '0;
                    k_d      = 2'd0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            idx_q    <= '0;
            src_re_q <= '0;
            src_im_q <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            ready_q  <= 1'b0;
            x_real_q <= '0;
            x_imag_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            idx_q    <= idx_d;
            src_re_q <= src_re_d;
            src_im_q <= src_im_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            ready_q  <= ready_d;
            x_real_q <= x_real_d;
            x_imag_q <= x_imag_d;
        end
    end

    assign ready  = ready_q;
    assign x_real = x_real_q;
    assign x_imag = x_imag_q;

endmodule : inv_dft_n4

// File: tb/tb_inv_dft_n4.sv
// -----------------------------------------------------------------------------
// tb_inv_dft_n4
// Directed, table-driven bench for inv_dft_n4 (WIDTH=24). Expected values are
// hand-computed from the inverse-DFT definition. Inputs are driven and outputs
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_inv_dft_n4;

    localparam int W = 24;

    typedef logic [3:0][W-1:0] spec_t;

    typedef struct {
        string      name;
        logic [1:0] idx;
        spec_t      re;
        spec_t      im;
        logic [W-1:0] exp_re;
        logic [W-1:0] exp_im;
    } vec_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   x_idx;
    spec_t        src_real;
    spec_t        src_imag;
    logic         ready;
    logic [W-1:0] x_real;
    logic [W-1:0] x_imag;

    int n_tests;
    int n_fail;

    inv_dft_n4 #(
        .WIDTH (W),
        .FRAC  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .x_idx    (x_idx),
        .src_real (src_real),
        .src_imag (src_imag),
        .ready    (ready),
        .x_real   (x_real),
        .x_imag   (x_imag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic spec_t mk(input logic [W-1:0] x0, input logic [W-1:0] x1,
                                 input logic [W-1:0] x2, input logic [W-1:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    // Launch one computation, confirm ready stays low through ACCUM, then
    // check the result right after the fourth accumulate edge.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        x_idx    = v.idx;
        src_real = v.re;
        src_imag = v.im;
        start    = 1'b1;
        @(negedge clk);              // after E0
        start = 1'b0;
        check({v.name, " ready_low_accum"}, 32'(ready), 32'd0);
        repeat (3) @(negedge clk);   // after E1..E3
        check({v.name, " ready_low_e3"}, 32'(ready), 32'd0);
        @(negedge clk);              // after E4
        check({v.name, " ready"}, 32'(ready), 32'd1);
        check({v.name, " x_real"}, 32'(x_real), 32'(v.exp_re));
        check({v.name, " x_imag"}, 32'(x_imag), 32'(v.exp_im));
    endtask

    vec_t vecs[10];

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        x_idx    = '0;
        src_real = '0;
        src_imag = '0;

        // Spectrum X = (0x500,0), (0,-0x100), (0x300,0), (0,0x100)
        vecs[0] = '{"n0", 2'd0, mk(24'h000500, 24'h0, 24'h000300, 24'h0),
                    mk(24'h0, 24'hffff00, 24'h0, 24'h000100), 24'h000200, 24'h0};
        vecs[1] = '{"n1", 2'd1, mk(24'h000500, 24'h0, 24'h000300, 24'h0),
                    mk(24'h0, 24'hffff00, 24'h0, 24'h000100), 24'h000100, 24'h0};
        vecs[2] = '{"n2", 2'd2, mk(24'h000500, 24'h0, 24'h000300, 24'h0),
                    mk(24'h0, 24'hffff00, 24'h0, 24'h000100), 24'h000200, 24'h0};
        vecs[3] = '{"n3", 2'd3, mk(24'h000500, 24'h0, 24'h000300, 24'h0),
                    mk(24'h0, 24'hffff00, 24'h0, 24'h000100), 24'h000000, 24'h0};
        // Floor shift: 3/4 -> 0, -3/4 -> -1
        vecs[4] = '{"floor_pos", 2'd2, mk(24'h000003, 24'h0, 24'h0, 24'h0),
                    '0, 24'h000000, 24'h0};
        vecs[5] = '{"floor_neg", 2'd0, mk(24'hfffffd, 24'h0, 24'h0, 24'h0),
                    '0, 24'hffffff, 24'h0};
        // Imaginary path: X1=(0x400,0), n=1 -> j*X1/4 = (0, 0x100)
        vecs[6] = '{"imag_rot1", 2'd1, mk(24'h0, 24'h000400, 24'h0, 24'h0),
                    '0, 24'h0, 24'h000100};
        // X3=(0x400,0), n=1 -> j^3*X3/4 = (0, -0x100)
        vecs[7] = '{"imag_rot3", 2'd1, mk(24'h0, 24'h0, 24'h0, 24'h000400),
                    '0, 24'h0, 24'hffff00};
        // Extremes with no wrap
        vecs[8] = '{"all_min", 2'd0, {4{24'h800000}}, {4{24'h800000}},
                    24'h800000, 24'h800000};
        vecs[9] = '{"all_max", 2'd0, {4{24'h7fffff}}, {4{24'h7fffff}},
                    24'h7fffff, 24'h7fffff};

        // ---------------- reset state ----------------
        #12;
        check("rst ready", 32'(ready), 32'd0);
        check("rst x_real", 32'(x_real), 32'd0);
        check("rst x_imag", 32'(x_imag), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // ---------------- hold in DONE ----------------
        repeat (3) @(negedge clk);
        check("done_hold ready", 32'(ready), 32'd1);
        check("done_hold x_real", 32'(x_real), 32'h7fffff);

        // ---------------- reset mid-ACCUM ----------------
        @(negedge clk);
        x_idx    = 2'd1;
        src_real = vecs[1].re;
        src_imag = vecs[1].im;
        start    = 1'b1;
        @(negedge clk);               // after E0
        start = 1'b0;
        repeat (2) @(negedge clk);    // after E1, E2
        #2 reset = 1'b0;
        #1;
        check("midrst ready", 32'(ready), 32'd0);
        check("midrst x_real", 32'(x_real), 32'd0);
        check("midrst x_imag", 32'(x_imag), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst idle", 32'(ready), 32'd0);
        run_vec(vecs[1]);

        // ---------------- inputs change after latching ----------------
        @(negedge clk);
        x_idx    = 2'd1;
        src_real = vecs[1].re;
        src_imag = vecs[1].im;
        start    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            start    = 1'b0;
            x_idx    = 2'($urandom_range(0, 3));
            src_real = {$urandom(), $urandom(), $urandom()};
            src_imag = {$urandom(), $urandom(), $urandom()};
        end
        @(negedge clk);
        check("latched ready", 32'(ready), 32'd1);
        check("latched x_real", 32'(x_real), 32'h000100);
        check("latched x_imag", 32'(x_imag), 32'h000000);

        // ---------------- start pulsed mid-ACCUM ----------------
        @(negedge clk);
        x_idx    = 2'd0;
        src_real = vecs[0].re;
        src_imag = vecs[0].im;
        start    = 1'b1;
        @(negedge clk);  start = 1'b0;   // after E0
        @(negedge clk);  start = 1'b1;   // after E1
        @(negedge clk);  start = 1'b0;   // after E2 (start seen at E2)
        @(negedge clk);                  // after E3
        check("midstart early", 32'(ready), 32'd0);
        @(negedge clk);                  // after E4
        check("midstart ready", 32'(ready), 32'd1);
        check("midstart x_real", 32'(x_real), 32'h000200);

        // ---------------- start held high ----------------
        begin
            int last    = -1;
            int pulses  = 0;
            logic prev  = 1'b0;
            x_idx    = 2'd2;
            src_real = vecs[2].re;
            src_imag = vecs[2].im;
            start    = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (ready) begin
                    if (last < 0) check("held first", 32'(c), 32'd4);
                    else          check("held period", 32'(c - last), 32'd5);
                    check("held width", 32'(prev), 32'd0);
                    check("held x_real", 32'(x_real), 32'h000200);
                    last = c;
                    pulses++;
                end
                prev = ready;
            end
            check("held pulses", 32'(pulses), 32'd4);
            start = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_inv_dft_n4
